// File: rtl/bcd_mmss_counter.sv
// Minutes:seconds BCD timekeeper for the multiplexed 7-segment display.
// A prescaler turns clk into a once-per-second advance, and a BCD cascade counts 00:00..59:59.
module bcd_mmss_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        run,
    input  logic        clear,
    input  logic        min_inc,
    output logic [15:0] digits,
    output logic        sec_tick,
    output logic        hour_carry,
    output logic        colon_blink
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sec_ones_q, sec_ones_d;
    logic [3:0]       sec_tens_q, sec_tens_d;
    logic [3:0]       min_ones_q, min_ones_d;
    logic [3:0]       min_tens_q, min_tens_d;
    logic             sec_tick_q, sec_tick_d;
    logic             hour_carry_q, hour_carry_d;

    logic             adv;
    logic             sec_carry;
    logic [7:0]       min_after_tick;
    logic [7:0]       min_after_inc;

    // One-minute BCD step on {tens, ones}; 59 wraps to 00.
    function automatic logic [7:0] min_step(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones == 4'd9) begin
            if (tens == 4'd5) r = 8'h00;
            else              r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        cnt_d          = cnt_q;
        sec_ones_d     = sec_ones_q;
        sec_tens_d     = sec_tens_q;
        adv            = 1'b0;
        sec_carry      = 1'b0;

        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                adv   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (adv) begin
            if (sec_ones_q == 4'd9) begin
                sec_ones_d = 4'd0;
                if (sec_tens_q == 4'd5) begin
                    sec_tens_d = 4'd0;
                    sec_carry  = 1'b1;
                end else begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end
            end else begin
                sec_ones_d = sec_ones_q + 4'd1;
            end
        end

        // Tick carry is applied before min_inc so only a tick-driven 59->00 wrap flags hour_carry.
        min_after_tick = sec_carry ? min_step(min_tens_q, min_ones_q) : {min_tens_q, min_ones_q};
        min_after_inc  = min_inc ? min_step(min_after_tick[7:4], min_after_tick[3:0]) : min_after_tick;
        min_tens_d     = min_after_inc[7:4];
        min_ones_d     = min_after_inc[3:0];
        sec_tick_d     = adv;
        hour_carry_d   = sec_carry && (min_tens_q == 4'd5) && (min_ones_q == 4'd9);

        if (clear) begin
            cnt_d        = '0;
            sec_ones_d   = 4'd0;
            sec_tens_d   = 4'd0;
            min_ones_d   = 4'd0;
            min_tens_d   = 4'd0;
            sec_tick_d   = 1'b0;
            hour_carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_q        <= '0;
            sec_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            min_tens_q   <= 4'd0;
            sec_tick_q   <= 1'b0;
            hour_carry_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sec_ones_q   <= sec_ones_d;
            sec_tens_q   <= sec_tens_d;
            min_ones_q   <= min_ones_d;
            min_tens_q   <= min_tens_d;
            sec_tick_q   <= sec_tick_d;
            hour_carry_q <= hour_carry_d;
        end
    end

    assign digits      = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
    assign sec_tick    = sec_tick_q;
    assign hour_carry  = hour_carry_q;
    assign colon_blink = (cnt_q < CNT_HALF);

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// Directed bench for bcd_mmss_counter with a 4-cycle second.
module tb_bcd_mmss_counter;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        min_inc = 1'b0;
    logic [15:0] digits;
    logic        sec_tick;
    logic        hour_carry;
    logic        colon_blink;

    int total = 0;
    int bad   = 0;

    bcd_mmss_counter #(.TICK_DIV(TICK_DIV), .CNT_W(2)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .run        (run),
        .clear      (clear),
        .min_inc    (min_inc),
        .digits     (digits),
        .sec_tick   (sec_tick),
        .hour_carry (hour_carry),
        .colon_blink(colon_blink)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then stable for checking and inputs may be changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, set minutes via min_inc, then run whole seconds; leaves prescaler=0 and run=0.
    task automatic go_to(input int m, input int s);
        RESET = 1'b1; run = 1'b0; clear = 1'b0; min_inc = 1'b0;
        step();
        RESET = 1'b0;
        for (int i = 0; i < m; i++) begin
            min_inc = 1'b1; step(); min_inc = 1'b0;
        end
        run = 1'b1;
        for (int i = 0; i < s * TICK_DIV; i++) step();
        run = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; run = 1'b1; clear = 1'b0; min_inc = 1'b1;
        step();
        RESET = 1'b0; run = 1'b0; min_inc = 1'b0;
        total++;
        if (digits !== 16'h0000 || sec_tick !== 1'b0 || hour_carry !== 1'b0 || colon_blink !== 1'b1) begin
            bad++;
            $display("FAIL reset: digits=%h tick=%b carry=%b colon=%b, want 0000 0 0 1",
                     digits, sec_tick, hour_carry, colon_blink);
        end
        $display("reset: digits=%h colon=%b", digits, colon_blink);
    endtask

    task automatic test_count();
        logic [15:0] exp_d;
        logic        exp_t, exp_c;
        go_to(0, 0);
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_d = 16'(k / TICK_DIV);
            exp_t = (k % TICK_DIV) == 0;
            exp_c = (k % TICK_DIV) < (TICK_DIV / 2);
            total++;
            if (digits !== exp_d || sec_tick !== exp_t || colon_blink !== exp_c || hour_carry !== 1'b0) begin
                bad++;
                $display("FAIL count edge %0d: digits=%h tick=%b colon=%b carry=%b, want %h %b %b 0",
                         k, digits, sec_tick, colon_blink, hour_carry, exp_d, exp_t, exp_c);
            end
            $display("count edge %0d: digits=%h tick=%b colon=%b", k, digits, sec_tick, colon_blink);
        end
        run = 1'b0;
    endtask

    task automatic test_min_carry();
        logic saw_carry;
        go_to(0, 59);
        total++;
        if (digits !== 16'h0059) begin
            bad++;
            $display("FAIL preload 00:59: digits=%h want 0059", digits);
        end
        saw_carry = 1'b0;
        run = 1'b1;
        for (int k = 0; k < TICK_DIV; k++) begin
            step();
            if (hour_carry === 1'b1) saw_carry = 1'b1;
        end
        run = 1'b0;
        total++;
        if (digits !== 16'h0100 || sec_tick !== 1'b1 || saw_carry !== 1'b0) begin
            bad++;
            $display("FAIL 00:59->01:00: digits=%h tick=%b carry_seen=%b, want 0100 1 0",
                     digits, sec_tick, saw_carry);
        end
        $display("00:59 + 1s: digits=%h", digits);
    endtask

    task automatic test_hour_rollover();
        go_to(59, 59);
        total++;
        if (digits !== 16'h5959) begin
            bad++;
            $display("FAIL preload 59:59: digits=%h want 5959", digits);
        end
        run = 1'b1;
        for (int k = 0; k < TICK_DIV; k++) step();
        total++;
        if (digits !== 16'h0000 || sec_tick !== 1'b1 || hour_carry !== 1'b1) begin
            bad++;
            $display("FAIL 59:59 rollover: digits=%h tick=%b carry=%b, want 0000 1 1",
                     digits, sec_tick, hour_carry);
        end
        step();
        run = 1'b0;
        total++;
        if (sec_tick !== 1'b0 || hour_carry !== 1'b0 || digits !== 16'h0000) begin
            bad++;
            $display("FAIL rollover pulse width: digits=%h tick=%b carry=%b, want 0000 0 0",
                     digits, sec_tick, hour_carry);
        end
        $display("59:59 rollover: digits=%h", digits);
    endtask

    task automatic test_back_to_back();
        go_to(59, 59);
        run = 1'b1;
        for (int k = 0; k < TICK_DIV - 1; k++) step();
        min_inc = 1'b1; step(); min_inc = 1'b0; run = 1'b0;
        total++;
        if (digits !== 16'h0100 || hour_carry !== 1'b1 || sec_tick !== 1'b1) begin
            bad++;
            $display("FAIL 59:59+tick+min_inc: digits=%h carry=%b tick=%b, want 0100 1 1",
                     digits, hour_carry, sec_tick);
        end
        $display("59:59 tick+min_inc: digits=%h carry=%b", digits, hour_carry);

        go_to(58, 59);
        run = 1'b1;
        for (int k = 0; k < TICK_DIV - 1; k++) step();
        min_inc = 1'b1; step(); min_inc = 1'b0; run = 1'b0;
        total++;
        if (digits !== 16'h0000 || hour_carry !== 1'b0 || sec_tick !== 1'b1) begin
            bad++;
            $display("FAIL 58:59+tick+min_inc: digits=%h carry=%b tick=%b, want 0000 0 1",
                     digits, hour_carry, sec_tick);
        end
        $display("58:59 tick+min_inc: digits=%h carry=%b", digits, hour_carry);
    endtask

    task automatic test_min_inc_frozen();
        logic saw_pulse;
        go_to(12, 34);
        run = 1'b1;
        step(); step();
        run = 1'b0;
        saw_pulse = 1'b0;
        for (int i = 0; i < 48; i++) begin
            min_inc = 1'b1; step(); min_inc = 1'b0;
            if (sec_tick === 1'b1 || hour_carry === 1'b1) saw_pulse = 1'b1;
            step();
            if (sec_tick === 1'b1 || hour_carry === 1'b1) saw_pulse = 1'b1;
        end
        total++;
        if (digits !== 16'h0034 || saw_pulse !== 1'b0 || colon_blink !== 1'b0) begin
            bad++;
            $display("FAIL min_inc x48 frozen: digits=%h pulse_seen=%b colon=%b, want 0034 0 0",
                     digits, saw_pulse, colon_blink);
        end
        $display("12:34 + 48 min: digits=%h", digits);
        // Prescaler was held at 2, so two more run edges complete the second.
        run = 1'b1;
        step();
        total++;
        if (digits !== 16'h0034 || sec_tick !== 1'b0) begin
            bad++;
            $display("FAIL resume edge 1: digits=%h tick=%b, want 0034 0", digits, sec_tick);
        end
        step();
        run = 1'b0;
        total++;
        if (digits !== 16'h0035 || sec_tick !== 1'b1) begin
            bad++;
            $display("FAIL resume edge 2: digits=%h tick=%b, want 0035 1", digits, sec_tick);
        end
        $display("resume: digits=%h tick=%b", digits, sec_tick);
    endtask

    task automatic test_clear(input logic use_reset);
        go_to(7, 21);
        run = 1'b1;
        step(); step();
        total++;
        if (digits !== 16'h0721 || colon_blink !== 1'b0) begin
            bad++;
            $display("FAIL preload 07:21: digits=%h colon=%b, want 0721 0", digits, colon_blink);
        end
        min_inc = 1'b1;
        if (use_reset) RESET = 1'b1;
        else           clear = 1'b1;
        step();
        RESET = 1'b0; clear = 1'b0; min_inc = 1'b0; run = 1'b0;
        total++;
        if (digits !== 16'h0000 || colon_blink !== 1'b1 || sec_tick !== 1'b0 || hour_carry !== 1'b0) begin
            bad++;
            $display("FAIL %s at 07:21: digits=%h colon=%b tick=%b carry=%b, want 0000 1 0 0",
                     use_reset ? "reset" : "clear", digits, colon_blink, sec_tick, hour_carry);
        end
        $display("%s at 07:21: digits=%h colon=%b", use_reset ? "reset" : "clear", digits, colon_blink);
    endtask

    initial begin
        test_reset();
        test_count();
        test_min_carry();
        test_hour_rollover();
        test_back_to_back();
        test_min_inc_frozen();
        test_clear(1'b0);
        test_clear(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, want finish before limit");
        $fatal(1, "timeout");
    end

endmodule
